// File: rtl/fifo_burst_reader.sv
// Burst reader for the read side of the async PCIe DMA data FIFO; a 2-entry prefetch buffer absorbs the FIFO read latency.
// Define FIFO_RD_TIMEOUT_EN to flush a partial burst after TIMEOUT_CYC idle cycles below the burst threshold.
//
// state | meaning
// IDLE  | waiting for the water level (or the idle timeout) to start a burst
// BURST | issuing FIFO reads until len reads have been issued
// DRAIN | all reads issued; streaming the rest of the burst out of the buffer
module fifo_burst_reader #(
    parameter int DATA_WIDTH  = 128,
    parameter int LEVEL_WIDTH = 11,
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic [7:0]             m_len,
    output logic                   busy,
    output logic [15:0]            burst_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEVEL_WIDTH-1:0] BURST_LEVEL = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [7:0]             BURST_LEN_B = 8'(BURST_LEN);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            len;
    logic [7:0]            issued;
    logic [7:0]            sent;
    logic                  inflight;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  pop;
    logic                  last_beat;
    logic                  full_start;
    logic                  start;
    logic [7:0]            start_len;
    logic [1:0]            occupancy;

    assign full_start = (fifo_rd_water_level >= BURST_LEVEL);

`ifdef FIFO_RD_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        partial;
    logic        timeout_hit;

    assign partial     = (fifo_rd_water_level != '0) && !full_start;
    assign timeout_hit = partial && (idle_cnt == 16'(TIMEOUT_CYC - 1));
    assign start       = full_start || timeout_hit;
    assign start_len   = full_start ? BURST_LEN_B : 8'(fifo_rd_water_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state == IDLE && partial && !timeout_hit) begin
            idle_cnt <= idle_cnt + 16'd1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign start     = full_start;
    assign start_len = BURST_LEN_B;
`endif

    assign pop       = m_valid && m_ready;
    assign last_beat = pop && (sent == len - 8'd1);
    // Occupancy after this cycle's pop, so a beat leaving frees its slot for a read in the same cycle.
    assign occupancy = buf_cnt + {1'b0, inflight} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BURST;
            BURST:   if (issued == len) state_nxt = DRAIN;
            DRAIN:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        if (state == BURST && issued < len && !fifo_rd_empty && occupancy < 2'd2) begin
            fifo_rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            issued    <= '0;
            sent      <= '0;
            burst_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                len    <= start_len;
                issued <= '0;
                sent   <= '0;
            end else begin
                if (fifo_rd_en) issued <= issued + 8'd1;
                if (pop)        sent   <= sent + 8'd1;
            end
            if (state == DRAIN && last_beat) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            buf_cnt  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) begin
            buf_mem[wr_ptr] <= fifo_rd_data;
        end
    end

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_mem[rd_ptr];
    assign m_sop   = m_valid && (sent == 8'd0);
    assign m_eop   = m_valid && (sent == len - 8'd1);
    assign m_len   = len;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model with one-cycle read latency and a beat scoreboard.
module tb_fifo_burst_reader;

    localparam int DW = 128;
    localparam int LW = 11;
    localparam int BL = 16;
    localparam int TO = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [7:0]    len;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic [LW-1:0] fifo_rd_water_level = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;
    logic [7:0]    m_len;
    logic          busy;
    logic [15:0]   burst_cnt;

    fifo_burst_reader dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .m_data              (m_data),
        .m_sop               (m_sop),
        .m_eop               (m_eop),
        .m_len               (m_len),
        .busy                (busy),
        .burst_cnt           (burst_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q [$];
    beat_t         exp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          rdy = 1'b1;
    logic          hold_empty = 1'b0;
    logic          last_rd = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            rd_pulses = 0;
    int            beats = 0;
    int            eops = 0;
    int            first_rd = 0;
    int            first_valid = 0;
    int            last_valid = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load_burst(input int n, input logic [DW-1:0] base, input logic expect_out);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            if (expect_out) begin
                b.data = base + DW'(i);
                b.sop  = (i == 0);
                b.eop  = (i == n - 1);
                b.len  = 8'(n);
                exp_q.push_back(b);
            end
        end
    endtask

    // One cycle: FIFO model update at negedge, then sample and score 1 time unit later.
    task automatic step();
        beat_t b;
        @(negedge clk);
        if (last_rd) begin
            check_val("fifo_nonempty_on_pop", DW'(fifo_q.size() != 0), DW'(1));
            if (fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
        end
        m_ready             = rdy;
        fifo_rd_empty       = hold_empty || (fifo_q.size() == 0);
        fifo_rd_water_level = LW'(fifo_q.size());
        #1;
        if (fifo_rd_en) begin
            rd_pulses++;
            check_val("rd_en_on_empty", DW'(fifo_rd_empty), DW'(0));
        end
        if (prev_stall) begin
            check_val("stall_valid", DW'(m_valid), DW'(1));
            check_val("stall_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            check_val("beat_expected", DW'(exp_q.size() != 0), DW'(1));
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check_val("beat_data", m_data, b.data);
                check_val("beat_sop", DW'(m_sop), DW'(b.sop));
                check_val("beat_eop", DW'(m_eop), DW'(b.eop));
                check_val("beat_len", DW'(m_len), DW'(b.len));
            end
            beats++;
            if (m_eop) eops++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        last_rd    = fifo_rd_en;
    endtask

    task automatic run_burst(input int budget);
        int done;
        done        = 0;
        first_rd    = 0;
        first_valid = 0;
        last_valid  = 0;
        for (int c = 1; c <= budget && done == 0; c++) begin
            step();
            if (fifo_rd_en && first_rd == 0) first_rd = c;
            if (m_valid) begin
                if (first_valid == 0) first_valid = c;
                last_valid = c;
            end
            if (!busy && exp_q.size() == 0) done = 1;
        end
        check_val("burst_done_in_budget", DW'(done), DW'(1));
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c;
        c = 0;
        while (beats < n && c < budget) begin
            step();
            c++;
        end
        check_val("beats_in_budget", DW'(beats >= n), DW'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_rd_en", DW'(fifo_rd_en), DW'(0));
        check_val("rst_m_valid", DW'(m_valid), DW'(0));
        check_val("rst_m_sop", DW'(m_sop), DW'(0));
        check_val("rst_m_eop", DW'(m_eop), DW'(0));
        check_val("rst_m_len", DW'(m_len), DW'(0));
        check_val("rst_busy", DW'(busy), DW'(0));
        check_val("rst_burst_cnt", DW'(burst_cnt), DW'(0));
        fifo_q.delete();
        exp_q.delete();
        last_rd             = 1'b0;
        prev_stall          = 1'b0;
        fifo_rd_empty       = 1'b1;
        fifo_rd_water_level = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Full burst at 1 beat/cycle; rd_en one edge after the level is seen, first valid two edges after.
        beats = 0; eops = 0;
        load_burst(BL, 128'h0, 1'b1);
        run_burst(100);
        check_val("lat_first_rd", DW'(first_rd), DW'(2));
        check_val("lat_first_valid", DW'(first_valid), DW'(4));
        check_val("consecutive_beats", DW'(last_valid - first_valid), DW'(BL - 1));
        check_val("full_beats", DW'(beats), DW'(BL));
        check_val("full_eops", DW'(eops), DW'(1));
        check_val("full_burst_cnt", DW'(burst_cnt), DW'(1));
        check_val("full_idle", DW'(busy), DW'(0));

        // Backpressure on beat 3 for 10 cycles.
        beats = 0; eops = 0;
        load_burst(BL, 128'h100, 1'b1);
        wait_beats(3, 100);
        rdy = 1'b0;
        rd_pulses = 0;
        repeat (10) step();
        check_val("bp_rd_pulses_le2", DW'(rd_pulses <= 2), DW'(1));
        check_val("bp_head_beat3", m_data, 128'h103);
        rdy = 1'b1;
        run_burst(100);
        check_val("bp_beats", DW'(beats), DW'(BL));
        check_val("bp_eops", DW'(eops), DW'(1));
        check_val("bp_burst_cnt", DW'(burst_cnt), DW'(2));

        // Empty for 5 cycles after 7 reads.
        beats = 0; eops = 0;
        load_burst(BL, 128'h200, 1'b1);
        rd_pulses = 0;
        begin
            int c;
            c = 0;
            while (rd_pulses < 7 && c < 100) begin
                step();
                c++;
            end
        end
        check_val("empty_reads_before", DW'(rd_pulses), DW'(7));
        hold_empty = 1'b1;
        rd_pulses = 0;
        repeat (5) step();
        check_val("empty_no_reads", DW'(rd_pulses), DW'(0));
        check_val("empty_busy", DW'(busy), DW'(1));
        hold_empty = 1'b0;
        run_burst(100);
        check_val("empty_beats", DW'(beats), DW'(BL));
        check_val("empty_eops", DW'(eops), DW'(1));
        check_val("empty_burst_cnt", DW'(burst_cnt), DW'(3));

        // Below threshold: level 5.
        beats = 0; eops = 0;
`ifdef FIFO_RD_TIMEOUT_EN
        load_burst(5, 128'h300, 1'b1);
        run_burst(TO + 100);
        check_val("to_first_rd", DW'(first_rd), DW'(TO + 1));
        check_val("to_beats", DW'(beats), DW'(5));
        check_val("to_eops", DW'(eops), DW'(1));
        check_val("to_burst_cnt", DW'(burst_cnt), DW'(4));
`else
        load_burst(5, 128'h300, 1'b0);
        rd_pulses = 0;
        repeat (TO + 50) step();
        check_val("below_no_reads", DW'(rd_pulses), DW'(0));
        check_val("below_idle", DW'(busy), DW'(0));
        check_val("below_no_valid", DW'(m_valid), DW'(0));
`endif
        do_reset();

        // Reset at beat 8, then a clean burst.
        beats = 0; eops = 0;
        load_burst(BL, 128'h400, 1'b1);
        wait_beats(8, 100);
        do_reset();
        beats = 0; eops = 0;
        load_burst(BL, 128'h500, 1'b1);
        begin
            int c;
            c = 0;
            while (!m_valid && c < 50) begin
                step();
                c++;
            end
        end
        check_val("post_rst_sop", DW'(m_sop), DW'(1));
        check_val("post_rst_cnt0", DW'(burst_cnt), DW'(0));
        run_burst(100);
        check_val("post_rst_beats", DW'(beats), DW'(BL));
        check_val("post_rst_burst_cnt", DW'(burst_cnt), DW'(1));

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.burst_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.burst_cnt;
        #1;
        check_val("wrap_preset", DW'(burst_cnt), DW'(16'hFFFF));
        beats = 0; eops = 0;
        load_burst(BL, 128'h600, 1'b1);
        run_burst(100);
        check_val("wrap_beats", DW'(beats), DW'(BL));
        check_val("wrap_to_zero", DW'(burst_cnt), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
